rob: RTL and testbench
======================

Name: rob

Overview:
- 16-entry circular reorder buffer for the Tomasulo core.
- Allocates a tag per issued instruction and collects results from two CDBs (ALU and LSB).
- Answers rename-table operand lookups and retires in program order.
- Drives the register-file commit port, the LSB store-release pulse, and the global clear/redirect on branch mispredict.

Parameters:
- ROB_WIDTH, 4, tag width
- ROB_SIZE, 16, entries (must equal 2**ROB_WIDTH)

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-low reset
- rdy  in  1  global ready; low freezes state
- dc_valid  in  1  decoder issue request
- dc_type  in  2  0=REG write, 1=STORE, 2=BRANCH (3 reserved, treated as REG)
- dc_rd  in  5  destination register
- rob_en  out  4  tag granted to the issuing instruction (= tail)
- rob_full  out  1  no free entry
- to_rob_Qj, to_rob_Qk  in  4  tags being looked up by the register file
- rob_Qj_ok, rob_Qk_ok  out  1  looked-up value available
- rob_Vj, rob_Vk  out  32  looked-up value
- alu_cdb_valid  in  1  ALU result broadcast
- alu_cdb_tag  in  4  ALU result tag
- alu_cdb_val  in  32  ALU result value
- alu_cdb_mispred  in  1  branch outcome differs from prediction
- alu_cdb_target  in  32  correct next PC
- lsb_cdb_valid  in  1  LSB broadcast: load data or store address ready
- lsb_cdb_tag  in  4  LSB tag
- lsb_cdb_val  in  32  LSB value
- rob_commit  out  1  register commit pulse
- rob_commit_en  out  4  committing tag
- rob_commit_val  out  32  committed value
- rob_commit_addr  out  5  committed destination register
- store_commit  out  1  release store at head to memory
- store_commit_tag  out  4  tag of released store
- clear  out  1  flush pulse to all units
- redirect_pc  out  32  fetch target, valid while clear=1

Behaviour:
- Entry fields: busy, ready, type[1:0], rd[4:0], val[31:0], mispred, target[31:0].
- Pointers: head, tail (4 bits, wrap 15→0); count (5 bits, 0..16).
- Reset (rst=0, async): head=tail=count=0, all busy/ready=0. All outputs 0, including rob_en=0 and rob_full=0.
- rdy=0: no state change; registered pulse outputs (rob_commit, store_commit, clear) forced to 0.
- rob_en = tail and rob_full = (count==16), both combinational from pre-edge state.
- Issue: dc_valid && !rob_full at the edge writes entry[tail] with busy=1, ready=0, type, rd; then tail++.
- Writeback: a CDB valid whose tag hits a busy entry sets ready=1 and val; ALU also latches mispred/target. ALU and LSB on distinct tags in the same cycle are both applied. Same tag on both CDBs is illegal and unchecked. A CDB hit on a non-busy entry is ignored.
- Lookup (combinational): Qx_ok=1 when entry[tag] is busy and ready, or a valid CDB this cycle carries that tag (bypass; ALU wins). Vx is the matching value, else 0.
- Commit (at most one per cycle, decided on pre-edge state): when count>0 and entry[head] is ready:
  - REG: next cycle rob_commit=1 with en=head, val, addr=rd; rd=0 is still pulsed, and the register file ignores it.
  - STORE: next cycle store_commit=1, store_commit_tag=head.
  - BRANCH, mispred=0: retire silently. BRANCH links rd are committed as REG by the decoder using type 0.
  - BRANCH, mispred=1: next cycle clear=1 and redirect_pc=target.
  - In every case: busy[head]=0, head++.
- Flush (commit of a mispredicted branch): at that same edge set head=tail=count=0 and clear all busy bits. Issue and CDB writes arriving at that edge are discarded. During the following clear=1 cycle, issue is refused (rob_full reads 1) and CDB writes are ignored.
- Simultaneous issue and commit: count unchanged.
- Full with commit in the same cycle: issue is still refused.
- Issue into an entry freed by the same-edge commit is impossible, since full is evaluated pre-commit.
- Latency: a result broadcast at edge N is committed at edge N+1; the rob_commit pulse is visible in the cycle after edge N+1.

Decomposition:
- Shared package: ROB_WIDTH, ROB_SIZE, type encodings (TYPE_REG/STORE/BRANCH), NO_DEP=16 sentinel (used by the register-file Q outputs).
- No sub-module; the entry array is flat registers inside rob.

Test Plan:
- Reset release, issue REG rd=5; ALU cdb tag0 val=0x1234 → next cycle rob_commit=1, en=0, addr=5, val=0x1234; count returns to 0.
- Issue 16 instructions → rob_full=1 after the 16th; a 17th dc_valid is ignored; tail wraps to 0; commit head, and the next issue gets rob_en=0.
- Lookup tag3 while alu_cdb_tag=3 val=7 is on the bus → rob_Qj_ok=1, rob_Vj=7 in the same cycle. Before the broadcast, ok=0 and V=0.
- Results in reverse order (tag2, tag1, then tag0) → commits for tags 0, 1, 2 on three consecutive cycles, in order.
- BRANCH tag1 with mispred=1, target=0x100, behind REG tag0 and followed by tags 2–4 → tag0 commits, then clear=1 with redirect_pc=0x100; tags 2–4 are never committed; count=0; the next issue gets rob_en=0.
- STORE at head made ready by lsb_cdb → store_commit=1, store_commit_tag=head, rob_commit=0. Hold rdy=0 two cycles mid-sequence → no pulses and no pointer movement.

Source files
------------

// File: rtl/rob_pkg.sv
// Shared types and constants for the 16-entry reorder buffer.
// Also provides the operand lookup helper used by the rename path.
package rob_pkg;

   localparam int unsigned ROB_WIDTH = 4;
   localparam int unsigned ROB_SIZE  = 2 ** ROB_WIDTH;

   typedef logic [ROB_WIDTH-1:0] tag_t;
   typedef logic [ROB_WIDTH:0]   cnt_t;

   localparam cnt_t ROB_CNT_FULL = cnt_t'(ROB_SIZE);
   // Register-file Q value meaning "no pending producer".
   localparam cnt_t NO_DEP       = cnt_t'(ROB_SIZE);

   localparam logic [1:0] TYPE_REG    = 2'd0;
   localparam logic [1:0] TYPE_STORE  = 2'd1;
   localparam logic [1:0] TYPE_BRANCH = 2'd2;

   typedef struct packed {
      logic        busy;
      logic        ready;
      logic [1:0]  typ;
      logic [4:0]  rd;
      logic [31:0] val;
      logic        mispred;
      logic [31:0] target;
   } rob_entry_t;

   typedef struct packed {
      logic        ok;
      logic [31:0] val;
   } lookup_t;

   // A committed-ready entry wins; otherwise bypass from the CDBs, ALU first.
   function automatic lookup_t rob_lookup(
      input tag_t        tag,
      input logic        ent_ready,
      input logic [31:0] ent_val,
      input logic        alu_valid,
      input tag_t        alu_tag,
      input logic [31:0] alu_val,
      input logic        lsb_valid,
      input tag_t        lsb_tag,
      input logic [31:0] lsb_val
   );
      lookup_t r;
      r = '0;
      if (ent_ready) begin
         r.ok  = 1'b1;
         r.val = ent_val;
      end else if (alu_valid && (alu_tag == tag)) begin
         r.ok  = 1'b1;
         r.val = alu_val;
      end else if (lsb_valid && (lsb_tag == tag)) begin
         r.ok  = 1'b1;
         r.val = lsb_val;
      end
      return r;
   endfunction

endpackage

// File: rtl/rob.sv
// Circular reorder buffer: tag allocation, CDB writeback, operand lookup and
// in-order retirement with register commit, store release and mispredict flush.
module rob
   import rob_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        rdy,

   input  logic        dc_valid,
   input  logic [1:0]  dc_type,
   input  logic [4:0]  dc_rd,
   output logic [3:0]  rob_en,
   output logic        rob_full,

   input  logic [3:0]  to_rob_Qj,
   input  logic [3:0]  to_rob_Qk,
   output logic        rob_Qj_ok,
   output logic        rob_Qk_ok,
   output logic [31:0] rob_Vj,
   output logic [31:0] rob_Vk,

   input  logic        alu_cdb_valid,
   input  logic [3:0]  alu_cdb_tag,
   input  logic [31:0] alu_cdb_val,
   input  logic        alu_cdb_mispred,
   input  logic [31:0] alu_cdb_target,

   input  logic        lsb_cdb_valid,
   input  logic [3:0]  lsb_cdb_tag,
   input  logic [31:0] lsb_cdb_val,

   output logic        rob_commit,
   output logic [3:0]  rob_commit_en,
   output logic [31:0] rob_commit_val,
   output logic [4:0]  rob_commit_addr,
   output logic        store_commit,
   output logic [3:0]  store_commit_tag,
   output logic        clear,
   output logic [31:0] redirect_pc
);

   rob_entry_t  entry_q [ROB_SIZE];
   rob_entry_t  entry_d [ROB_SIZE];
   tag_t        head_q, head_d;
   tag_t        tail_q, tail_d;
   cnt_t        count_q, count_d;

   logic        commit_q, commit_d;
   tag_t        commit_en_q, commit_en_d;
   logic [31:0] commit_val_q, commit_val_d;
   logic [4:0]  commit_addr_q, commit_addr_d;
   logic        store_q, store_d;
   tag_t        store_tag_q, store_tag_d;
   logic        clear_q, clear_d;
   logic [31:0] redirect_q, redirect_d;

   rob_entry_t  head_entry;
   logic        full;
   logic        do_issue;
   logic        do_commit;
   logic        flush;
   lookup_t     lk_j, lk_k;

   // The cycle after a flush looks full so the decoder cannot issue into it.
   always_comb begin
      head_entry = entry_q[head_q];
      full       = (count_q == ROB_CNT_FULL) || clear_q;
      do_issue   = dc_valid && !full;
      do_commit  = (count_q != '0) && head_entry.ready;
      flush      = do_commit && (head_entry.typ == TYPE_BRANCH) && head_entry.mispred;
   end

   always_comb begin
      lk_j = rob_lookup(to_rob_Qj, entry_q[to_rob_Qj].busy && entry_q[to_rob_Qj].ready,
                        entry_q[to_rob_Qj].val, alu_cdb_valid, alu_cdb_tag, alu_cdb_val,
                        lsb_cdb_valid, lsb_cdb_tag, lsb_cdb_val);
      lk_k = rob_lookup(to_rob_Qk, entry_q[to_rob_Qk].busy && entry_q[to_rob_Qk].ready,
                        entry_q[to_rob_Qk].val, alu_cdb_valid, alu_cdb_tag, alu_cdb_val,
                        lsb_cdb_valid, lsb_cdb_tag, lsb_cdb_val);
   end

   always_comb begin
      entry_d       = entry_q;
      head_d        = head_q;
      tail_d        = tail_q;
      count_d       = count_q;
      commit_d      = 1'b0;
      commit_en_d   = '0;
      commit_val_d  = '0;
      commit_addr_d = '0;
      store_d       = 1'b0;
      store_tag_d   = '0;
      clear_d       = 1'b0;
      redirect_d    = '0;

      if (rdy) begin
         if (alu_cdb_valid && !clear_q && entry_q[alu_cdb_tag].busy) begin
            entry_d[alu_cdb_tag].ready   = 1'b1;
            entry_d[alu_cdb_tag].val     = alu_cdb_val;
            entry_d[alu_cdb_tag].mispred = alu_cdb_mispred;
            entry_d[alu_cdb_tag].target  = alu_cdb_target;
         end
         if (lsb_cdb_valid && !clear_q && entry_q[lsb_cdb_tag].busy) begin
            entry_d[lsb_cdb_tag].ready = 1'b1;
            entry_d[lsb_cdb_tag].val   = lsb_cdb_val;
         end

         if (do_issue) begin
            entry_d[tail_q] = '{busy: 1'b1, ready: 1'b0, typ: dc_type, rd: dc_rd,
                                val: '0, mispred: 1'b0, target: '0};
            tail_d = tail_q + tag_t'(1);
         end

         if (do_commit) begin
            entry_d[head_q].busy  = 1'b0;
            entry_d[head_q].ready = 1'b0;
            head_d = head_q + tag_t'(1);
            if (head_entry.typ == TYPE_STORE) begin
               store_d     = 1'b1;
               store_tag_d = head_q;
            end else if (head_entry.typ == TYPE_BRANCH) begin
               if (head_entry.mispred) begin
                  clear_d    = 1'b1;
                  redirect_d = head_entry.target;
               end
            end else begin
               // Reserved type 3 retires like a register write.
               commit_d      = 1'b1;
               commit_en_d   = head_q;
               commit_val_d  = head_entry.val;
               commit_addr_d = head_entry.rd;
            end
         end

         count_d = count_q + cnt_t'(do_issue) - cnt_t'(do_commit);

         if (flush) begin
            for (int unsigned i = 0; i < ROB_SIZE; i++) begin
               entry_d[i].busy  = 1'b0;
               entry_d[i].ready = 1'b0;
            end
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int unsigned i = 0; i < ROB_SIZE; i++) begin
            entry_q[i] <= '0;
         end
         head_q        <= '0;
         tail_q        <= '0;
         count_q       <= '0;
         commit_q      <= 1'b0;
         commit_en_q   <= '0;
         commit_val_q  <= '0;
         commit_addr_q <= '0;
         store_q       <= 1'b0;
         store_tag_q   <= '0;
         clear_q       <= 1'b0;
         redirect_q    <= '0;
      end else begin
         entry_q       <= entry_d;
         head_q        <= head_d;
         tail_q        <= tail_d;
         count_q       <= count_d;
         commit_q      <= commit_d;
         commit_en_q   <= commit_en_d;
         commit_val_q  <= commit_val_d;
         commit_addr_q <= commit_addr_d;
         store_q       <= store_d;
         store_tag_q   <= store_tag_d;
         clear_q       <= clear_d;
         redirect_q    <= redirect_d;
      end
   end

   assign rob_en           = tail_q;
   assign rob_full         = full;
   assign rob_Qj_ok        = lk_j.ok;
   assign rob_Vj           = lk_j.val;
   assign rob_Qk_ok        = lk_k.ok;
   assign rob_Vk           = lk_k.val;
   assign rob_commit       = commit_q;
   assign rob_commit_en    = commit_en_q;
   assign rob_commit_val   = commit_val_q;
   assign rob_commit_addr  = commit_addr_q;
   assign store_commit     = store_q;
   assign store_commit_tag = store_tag_q;
   assign clear            = clear_q;
   assign redirect_pc      = redirect_q;

endmodule

// File: tb/tb_rob.sv
// Bench for rob: directed scenarios plus random traffic, all checked against a
// queue-based program-order model of the reorder buffer.
module tb_rob;

   logic        clk;
   logic        rst;
   logic        rdy;
   logic        dc_valid;
   logic [1:0]  dc_type;
   logic [4:0]  dc_rd;
   logic [3:0]  rob_en;
   logic        rob_full;
   logic [3:0]  to_rob_Qj, to_rob_Qk;
   logic        rob_Qj_ok, rob_Qk_ok;
   logic [31:0] rob_Vj, rob_Vk;
   logic        alu_cdb_valid;
   logic [3:0]  alu_cdb_tag;
   logic [31:0] alu_cdb_val;
   logic        alu_cdb_mispred;
   logic [31:0] alu_cdb_target;
   logic        lsb_cdb_valid;
   logic [3:0]  lsb_cdb_tag;
   logic [31:0] lsb_cdb_val;
   logic        rob_commit;
   logic [3:0]  rob_commit_en;
   logic [31:0] rob_commit_val;
   logic [4:0]  rob_commit_addr;
   logic        store_commit;
   logic [3:0]  store_commit_tag;
   logic        clear;
   logic [31:0] redirect_pc;

   rob dut (
      .clk(clk), .rst(rst), .rdy(rdy),
      .dc_valid(dc_valid), .dc_type(dc_type), .dc_rd(dc_rd),
      .rob_en(rob_en), .rob_full(rob_full),
      .to_rob_Qj(to_rob_Qj), .to_rob_Qk(to_rob_Qk),
      .rob_Qj_ok(rob_Qj_ok), .rob_Qk_ok(rob_Qk_ok),
      .rob_Vj(rob_Vj), .rob_Vk(rob_Vk),
      .alu_cdb_valid(alu_cdb_valid), .alu_cdb_tag(alu_cdb_tag),
      .alu_cdb_val(alu_cdb_val), .alu_cdb_mispred(alu_cdb_mispred),
      .alu_cdb_target(alu_cdb_target),
      .lsb_cdb_valid(lsb_cdb_valid), .lsb_cdb_tag(lsb_cdb_tag), .lsb_cdb_val(lsb_cdb_val),
      .rob_commit(rob_commit), .rob_commit_en(rob_commit_en),
      .rob_commit_val(rob_commit_val), .rob_commit_addr(rob_commit_addr),
      .store_commit(store_commit), .store_commit_tag(store_commit_tag),
      .clear(clear), .redirect_pc(redirect_pc)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
      end
   endtask

   // Reference model: in-flight instructions in program order.
   typedef struct {
      logic [3:0]  tag;
      logic [1:0]  typ;
      logic [4:0]  rd;
      bit          ready;
      logic [31:0] val;
      bit          mispred;
      logic [31:0] target;
   } ent_t;

   ent_t        q[$];
   logic [3:0]  m_tail;
   bit          m_clr;
   bit          e_commit, e_store, e_clear;
   logic [3:0]  e_cen, e_stag;
   logic [31:0] e_cval, e_rpc;
   logic [4:0]  e_caddr;

   function automatic void model_reset();
      q.delete();
      m_tail = '0; m_clr = 0;
      e_commit = 0; e_store = 0; e_clear = 0;
      e_cen = '0; e_stag = '0; e_cval = '0; e_rpc = '0; e_caddr = '0;
   endfunction

   function automatic int find(input logic [3:0] tag);
      int idx;
      idx = -1;
      foreach (q[i]) if (q[i].tag == tag) idx = i;
      return idx;
   endfunction

   function automatic void exp_lookup(input logic [3:0] tag, output logic ok,
                                      output logic [31:0] v);
      int idx;
      ok = 0; v = '0;
      idx = find(tag);
      if (idx >= 0 && q[idx].ready) begin
         ok = 1; v = q[idx].val;
      end else if (alu_cdb_valid && alu_cdb_tag == tag) begin
         ok = 1; v = alu_cdb_val;
      end else if (lsb_cdb_valid && lsb_cdb_tag == tag) begin
         ok = 1; v = lsb_cdb_val;
      end
   endfunction

   function automatic void model_edge();
      ent_t h;
      bit   com, full, fl;
      int   idx;
      e_commit = 0; e_store = 0; e_clear = 0;
      e_cen = '0; e_stag = '0; e_cval = '0; e_rpc = '0; e_caddr = '0;
      if (!rdy) begin
         m_clr = 0;
         return;
      end
      com = (q.size() > 0) && q[0].ready;
      if (com) h = q[0];
      if (!m_clr) begin
         idx = find(alu_cdb_tag);
         if (alu_cdb_valid && idx >= 0) begin
            q[idx].ready = 1; q[idx].val = alu_cdb_val;
            q[idx].mispred = alu_cdb_mispred; q[idx].target = alu_cdb_target;
         end
         idx = find(lsb_cdb_tag);
         if (lsb_cdb_valid && idx >= 0) begin
            q[idx].ready = 1; q[idx].val = lsb_cdb_val;
         end
      end
      full = (q.size() == 16) || m_clr;
      if (dc_valid && !full) begin
         q.push_back('{tag: m_tail, typ: dc_type, rd: dc_rd, ready: 0, val: '0,
                       mispred: 0, target: '0});
         m_tail = m_tail + 4'd1;
      end
      fl = 0;
      if (com) begin
         void'(q.pop_front());
         if (h.typ == 2'd1) begin
            e_store = 1; e_stag = h.tag;
         end else if (h.typ == 2'd2) begin
            if (h.mispred) begin
               fl = 1; e_clear = 1; e_rpc = h.target;
            end
         end else begin
            e_commit = 1; e_cen = h.tag; e_cval = h.val; e_caddr = h.rd;
         end
      end
      if (fl) begin
         q.delete();
         m_tail = '0;
      end
      m_clr = fl;
   endfunction

   task automatic set_idle();
      rdy = 1; dc_valid = 0; dc_type = '0; dc_rd = '0;
      to_rob_Qj = '0; to_rob_Qk = '0;
      alu_cdb_valid = 0; alu_cdb_tag = '0; alu_cdb_val = '0;
      alu_cdb_mispred = 0; alu_cdb_target = '0;
      lsb_cdb_valid = 0; lsb_cdb_tag = '0; lsb_cdb_val = '0;
   endtask

   // Called at a negedge with inputs driven; returns at the next negedge.
   task automatic cycle();
      logic        ok;
      logic [31:0] v;
      #1;
      check_eq("rob_en", 32'(rob_en), 32'(m_tail));
      check_eq("rob_full", 32'(rob_full), 32'((q.size() == 16) || m_clr));
      exp_lookup(to_rob_Qj, ok, v);
      check_eq("Qj_ok", 32'(rob_Qj_ok), 32'(ok));
      check_eq("Vj", rob_Vj, v);
      exp_lookup(to_rob_Qk, ok, v);
      check_eq("Qk_ok", 32'(rob_Qk_ok), 32'(ok));
      check_eq("Vk", rob_Vk, v);
      @(posedge clk);
      model_edge();
      #1;
      check_eq("rob_commit", 32'(rob_commit), 32'(e_commit));
      check_eq("commit_en", 32'(rob_commit_en), 32'(e_cen));
      check_eq("commit_val", rob_commit_val, e_cval);
      check_eq("commit_addr", 32'(rob_commit_addr), 32'(e_caddr));
      check_eq("store_commit", 32'(store_commit), 32'(e_store));
      check_eq("store_tag", 32'(store_commit_tag), 32'(e_stag));
      check_eq("clear", 32'(clear), 32'(e_clear));
      check_eq("redirect_pc", redirect_pc, e_rpc);
      @(negedge clk);
   endtask

   task automatic do_reset();
      set_idle();
      rst = 0;
      #1;
      check_eq("rst_en", 32'(rob_en), 32'd0);
      check_eq("rst_full", 32'(rob_full), 32'd0);
      check_eq("rst_commit", 32'(rob_commit), 32'd0);
      check_eq("rst_store", 32'(store_commit), 32'd0);
      check_eq("rst_clear", 32'(clear), 32'd0);
      check_eq("rst_rpc", redirect_pc, 32'd0);
      check_eq("rst_Qj_ok", 32'(rob_Qj_ok), 32'd0);
      model_reset();
      @(negedge clk);
      rst = 1;
   endtask

   task automatic issue(input logic [1:0] t, input logic [4:0] rd);
      set_idle();
      dc_valid = 1; dc_type = t; dc_rd = rd;
      cycle();
   endtask

   task automatic rand_inputs();
      logic [3:0] cand[$];
      int         k;
      set_idle();
      rdy       = ($urandom_range(0, 9) != 0);
      dc_valid  = ($urandom_range(0, 9) < 6);
      dc_type   = 2'($urandom_range(0, 3));
      dc_rd     = 5'($urandom_range(0, 31));
      to_rob_Qj = 4'($urandom_range(0, 15));
      to_rob_Qk = 4'($urandom_range(0, 15));
      foreach (q[i]) if (!q[i].ready) cand.push_back(q[i].tag);
      if (cand.size() > 0 && $urandom_range(0, 1) == 1) begin
         k = $urandom_range(0, cand.size() - 1);
         alu_cdb_valid   = 1;
         alu_cdb_tag     = cand[k];
         alu_cdb_val     = $urandom;
         alu_cdb_mispred = ($urandom_range(0, 7) == 0);
         alu_cdb_target  = $urandom;
         cand.delete(k);
      end
      if (cand.size() > 0 && $urandom_range(0, 2) != 0) begin
         k = $urandom_range(0, cand.size() - 1);
         lsb_cdb_valid = 1;
         lsb_cdb_tag   = cand[k];
         lsb_cdb_val   = $urandom;
      end
      // Occasional stray broadcast, possibly to an idle or already-ready entry.
      if (!alu_cdb_valid && $urandom_range(0, 9) == 0) begin
         alu_cdb_valid = 1;
         alu_cdb_tag   = 4'($urandom_range(0, 15));
         if (lsb_cdb_valid && alu_cdb_tag == lsb_cdb_tag) alu_cdb_tag = alu_cdb_tag + 4'd1;
         alu_cdb_val   = $urandom;
      end
   endtask

   initial begin
      rst = 0;
      set_idle();
      model_reset();
      @(negedge clk);
      do_reset();

      // Single REG issue and writeback.
      issue(2'd0, 5'd5);
      set_idle();
      alu_cdb_valid = 1; alu_cdb_tag = 4'd0; alu_cdb_val = 32'h1234;
      cycle();
      set_idle();
      cycle();
      check_eq("t1_commit", 32'(rob_commit), 32'd1);
      check_eq("t1_en", 32'(rob_commit_en), 32'd0);
      check_eq("t1_addr", 32'(rob_commit_addr), 32'd5);
      check_eq("t1_val", rob_commit_val, 32'h1234);
      cycle();

      // Fill to 16, 17th refused, wrap.
      do_reset();
      for (int i = 0; i < 16; i++) issue(2'd0, 5'(i + 1));
      set_idle();
      dc_valid = 1; dc_rd = 5'd20;
      #1;
      check_eq("t2_full", 32'(rob_full), 32'd1);
      check_eq("t2_wrap", 32'(rob_en), 32'd0);
      cycle();
      set_idle();
      alu_cdb_valid = 1; alu_cdb_tag = 4'd0; alu_cdb_val = 32'hBEEF;
      cycle();
      set_idle();
      cycle();
      check_eq("t2_commit0", 32'(rob_commit_en), 32'd0);
      set_idle();
      dc_valid = 1; dc_rd = 5'd21;
      #1;
      check_eq("t2_reissue_en", 32'(rob_en), 32'd0);
      check_eq("t2_not_full", 32'(rob_full), 32'd0);
      cycle();

      // Lookup bypass from the ALU CDB.
      do_reset();
      for (int i = 0; i < 4; i++) issue(2'd0, 5'(i + 1));
      set_idle();
      to_rob_Qj = 4'd3;
      #1;
      check_eq("t3_ok_before", 32'(rob_Qj_ok), 32'd0);
      check_eq("t3_v_before", rob_Vj, 32'd0);
      cycle();
      set_idle();
      to_rob_Qj = 4'd3;
      alu_cdb_valid = 1; alu_cdb_tag = 4'd3; alu_cdb_val = 32'd7;
      #1;
      check_eq("t3_ok_bypass", 32'(rob_Qj_ok), 32'd1);
      check_eq("t3_v_bypass", rob_Vj, 32'd7);
      cycle();

      // Out-of-order results, in-order commits.
      do_reset();
      for (int i = 0; i < 3; i++) issue(2'd0, 5'(i + 10));
      for (int t = 2; t >= 0; t--) begin
         set_idle();
         alu_cdb_valid = 1; alu_cdb_tag = 4'(t); alu_cdb_val = 32'(100 + t);
         cycle();
      end
      for (int t = 0; t < 3; t++) begin
         set_idle();
         cycle();
         check_eq("t4_commit", 32'(rob_commit), 32'd1);
         check_eq("t4_order", 32'(rob_commit_en), 32'(t));
      end

      // Mispredicted branch flushes younger work.
      do_reset();
      issue(2'd0, 5'd1);
      issue(2'd2, 5'd0);
      for (int i = 0; i < 3; i++) issue(2'd0, 5'(i + 2));
      set_idle();
      alu_cdb_valid = 1; alu_cdb_tag = 4'd1; alu_cdb_val = 32'h44;
      alu_cdb_mispred = 1; alu_cdb_target = 32'h100;
      lsb_cdb_valid = 1; lsb_cdb_tag = 4'd0; lsb_cdb_val = 32'hAA;
      cycle();
      set_idle();
      alu_cdb_valid = 1; alu_cdb_tag = 4'd2; alu_cdb_val = 32'h22;
      lsb_cdb_valid = 1; lsb_cdb_tag = 4'd3; lsb_cdb_val = 32'h33;
      cycle();
      check_eq("t5_commit0", 32'(rob_commit), 32'd1);
      check_eq("t5_val0", rob_commit_val, 32'hAA);
      set_idle();
      alu_cdb_valid = 1; alu_cdb_tag = 4'd4; alu_cdb_val = 32'h55;
      cycle();
      check_eq("t5_clear", 32'(clear), 32'd1);
      check_eq("t5_redirect", redirect_pc, 32'h100);
      set_idle();
      dc_valid = 1; dc_rd = 5'd7;
      #1;
      check_eq("t5_full_in_clear", 32'(rob_full), 32'd1);
      cycle();
      set_idle();
      dc_valid = 1; dc_rd = 5'd8;
      #1;
      check_eq("t5_en_after", 32'(rob_en), 32'd0);
      cycle();
      for (int i = 0; i < 3; i++) begin
         set_idle();
         cycle();
      end

      // Store release, with a two-cycle rdy stall.
      do_reset();
      issue(2'd1, 5'd0);
      issue(2'd0, 5'd9);
      set_idle();
      lsb_cdb_valid = 1; lsb_cdb_tag = 4'd0; lsb_cdb_val = 32'h8000;
      cycle();
      for (int i = 0; i < 2; i++) begin
         set_idle();
         rdy = 0;
         alu_cdb_valid = 1; alu_cdb_tag = 4'd1; alu_cdb_val = 32'h5;
         cycle();
         check_eq("t6_stall_store", 32'(store_commit), 32'd0);
         check_eq("t6_stall_en", 32'(rob_en), 32'd2);
      end
      set_idle();
      cycle();
      check_eq("t6_store", 32'(store_commit), 32'd1);
      check_eq("t6_store_tag", 32'(store_commit_tag), 32'd0);
      check_eq("t6_no_reg", 32'(rob_commit), 32'd0);
      set_idle();
      alu_cdb_valid = 1; alu_cdb_tag = 4'd1; alu_cdb_val = 32'h6;
      cycle();
      set_idle();
      cycle();

      // Random traffic.
      do_reset();
      for (int n = 0; n < 1500; n++) begin
         rand_inputs();
         cycle();
      end

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
